// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional jump support is enabled by defining CTRL_JUMP_EN.
module multicycle_control #(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned ALUOP_W  = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_eq,
   output logic                pc_write_ne,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [1:0]          pc_source,
   output logic                illegal,
   output logic [3:0]          state,
   output logic [CNT_W-1:0]    instr_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_IEXEC  = 4'd8,
      S_IWB    = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
   localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
   localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
`ifdef CTRL_JUMP_EN
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
`endif

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_ADDI  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_ANDI  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_ORI   = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(5);

   state_t              state_q, state_n, state_d;
   logic [OPCODE_W-1:0] op_q, op_n, op_d;
   logic                undef_n;
   logic                retire;
   logic                jump_q;

   logic                pc_write_eq_n, pc_write_ne_n, iord_n, mem_read_n, mem_write_n;
   logic                reg_dst_n, mem_to_reg_n, reg_write_n, alu_src_a_n, jump_n;
   logic [1:0]          alu_src_b_n, pc_source_n;
   logic [ALUOP_W-1:0]  alu_op_n;

   // Next state and opcode latch
   always_comb begin
      state_n = state_q;
      op_n    = op_q;
      undef_n = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_ready) state_n = S_DECODE;
         S_DECODE: begin
            op_n = opcode;
            case (opcode)
               OP_LW, OP_SW:             state_n = S_MEMADR;
               OP_RTYPE:                 state_n = S_EXEC;
               OP_ADDI, OP_ANDI, OP_ORI: state_n = S_IEXEC;
               OP_BEQ, OP_BNE:           state_n = S_BRANCH;
`ifdef CTRL_JUMP_EN
               OP_J:                     state_n = S_JUMP;
`endif
               default: begin
                  undef_n = 1'b1;
                  state_n = S_FETCH;
               end
            endcase
         end
         S_MEMADR: state_n = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_n = S_FETCH;
         S_EXEC:   state_n = S_ALUWB;
         S_IEXEC:  state_n = S_IWB;
         default:  state_n = S_FETCH;
      endcase
   end

   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_IWB) ||
                   (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                   ((state_q == S_MEMWR) && mem_ready);

   // Reset forces the FETCH decode so outputs stay consistent with state
   assign state_d = rst ? S_FETCH : state_n;
   assign op_d    = rst ? '0 : op_n;

   // Moore output decode of the upcoming state, registered alongside it
   always_comb begin
      pc_write_eq_n = 1'b0;
      pc_write_ne_n = 1'b0;
      iord_n        = 1'b0;
      mem_read_n    = 1'b0;
      mem_write_n   = 1'b0;
      reg_dst_n     = 1'b0;
      mem_to_reg_n  = 1'b0;
      reg_write_n   = 1'b0;
      alu_src_a_n   = 1'b0;
      jump_n        = 1'b0;
      alu_src_b_n   = 2'b00;
      pc_source_n   = 2'b00;
      alu_op_n      = ALU_ADD;
      case (state_d)
         S_FETCH: begin
            mem_read_n  = 1'b1;
            alu_src_b_n = 2'b01;
         end
         S_DECODE: alu_src_b_n = 2'b11;
         S_MEMADR: begin
            alu_src_a_n = 1'b1;
            alu_src_b_n = 2'b10;
         end
         S_MEMRD: begin
            mem_read_n = 1'b1;
            iord_n     = 1'b1;
         end
         S_MEMWB: begin
            reg_write_n  = 1'b1;
            mem_to_reg_n = 1'b1;
         end
         S_MEMWR: begin
            mem_write_n = 1'b1;
            iord_n      = 1'b1;
         end
         S_EXEC: begin
            alu_src_a_n = 1'b1;
            alu_op_n    = ALU_RTYPE;
         end
         S_ALUWB: begin
            reg_write_n = 1'b1;
            reg_dst_n   = 1'b1;
         end
         S_IEXEC: begin
            alu_src_a_n = 1'b1;
            alu_src_b_n = 2'b10;
            case (op_d)
               OP_ANDI: alu_op_n = ALU_ANDI;
               OP_ORI:  alu_op_n = ALU_ORI;
               default: alu_op_n = ALU_ADDI;
            endcase
         end
         S_IWB: reg_write_n = 1'b1;
         S_BRANCH: begin
            alu_src_a_n   = 1'b1;
            alu_op_n      = ALU_SUB;
            pc_source_n   = 2'b01;
            pc_write_eq_n = (op_d == OP_BEQ);
            pc_write_ne_n = (op_d == OP_BNE);
         end
         S_JUMP: begin
            pc_source_n = 2'b10;
            jump_n      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      state_q     <= state_d;
      op_q        <= op_d;
      pc_write_eq <= pc_write_eq_n;
      pc_write_ne <= pc_write_ne_n;
      iord        <= iord_n;
      mem_read    <= mem_read_n;
      mem_write   <= mem_write_n;
      reg_dst     <= reg_dst_n;
      mem_to_reg  <= mem_to_reg_n;
      reg_write   <= reg_write_n;
      alu_src_a   <= alu_src_a_n;
      alu_src_b   <= alu_src_b_n;
      alu_op      <= alu_op_n;
      pc_source   <= pc_source_n;
      jump_q      <= jump_n;
      if (rst) begin
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         illegal <= undef_n;
         if (retire) instr_count <= instr_count + CNT_W'(1);
      end
   end

   // IR/PC load in FETCH follows the memory handshake of the current cycle
   assign ir_write = (state_q == S_FETCH) && mem_ready;
   assign pc_write = ir_write || jump_q;
   assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second CNT_W=2 instance shares the stimulus
// to exercise counter wrap. Expectations follow CTRL_JUMP_EN when it is defined.
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BAD  = 6'h3F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = 6'h00;
   logic        mem_ready = 1'b0;

   logic        pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
   logic [1:0]  alu_src_b, pc_source;
   logic [2:0]  alu_op;
   logic [3:0]  state;
   logic [15:0] instr_count;

   logic        s_pc_write, s_pc_write_eq, s_pc_write_ne, s_iord, s_mem_read, s_mem_write;
   logic        s_ir_write, s_reg_dst, s_mem_to_reg, s_reg_write, s_alu_src_a, s_illegal;
   logic [1:0]  s_alu_src_b, s_pc_source;
   logic [2:0]  s_alu_op;
   logic [3:0]  s_state;
   logic [1:0]  s_instr_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   multicycle_control #(.OPCODE_W(6), .ALUOP_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal(illegal), .state(state), .instr_count(instr_count)
   );

   multicycle_control #(.OPCODE_W(6), .ALUOP_W(3), .CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(s_pc_write), .pc_write_eq(s_pc_write_eq), .pc_write_ne(s_pc_write_ne),
      .iord(s_iord), .mem_read(s_mem_read), .mem_write(s_mem_write), .ir_write(s_ir_write),
      .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg), .reg_write(s_reg_write),
      .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
      .pc_source(s_pc_source), .illegal(s_illegal), .state(s_state),
      .instr_count(s_instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Apply inputs just after a rising edge, return at the falling edge for sampling
   task automatic drive(input logic r, input logic [5:0] op, input logic mr);
      @(posedge clk);
      #1;
      rst       = r;
      opcode    = op;
      mem_ready = mr;
      @(negedge clk);
   endtask

   task automatic step(input logic [5:0] op, input logic mr, input int exp_st);
      drive(1'b0, op, mr);
      check("state", 32'(state), 32'(exp_st));
   endtask

   task automatic check_count();
      check("instr_count", 32'(instr_count), 32'(exp_cnt));
      check("instr_count_w2", 32'(s_instr_count), 32'(exp_cnt % 4));
   endtask

   task automatic imm_instr(input logic [5:0] op, input int exp_aluop);
      step(op, 1'b1, 0);
      step(op, 1'b1, 1);
      step(OP_BAD, 1'b1, 8);
      check("iexec_alu_op", 32'(alu_op), 32'(exp_aluop));
      check("iexec_alu_src_b", 32'(alu_src_b), 32'd2);
      step(OP_BAD, 1'b1, 9);
      check("iwb_reg_write", 32'(reg_write), 32'd1);
      check("iwb_reg_dst", 32'(reg_dst), 32'd0);
      step(OP_R, 1'b0, 0);
      exp_cnt++;
      check_count();
   endtask

   task automatic branch_instr(input logic [5:0] op, input logic eq, input logic ne);
      step(op, 1'b1, 0);
      step(op, 1'b1, 1);
      step(op, 1'b1, 10);
      check("br_pc_write_eq", 32'(pc_write_eq), 32'(eq));
      check("br_pc_write_ne", 32'(pc_write_ne), 32'(ne));
      check("br_alu_op", 32'(alu_op), 32'd5);
      check("br_pc_source", 32'(pc_source), 32'd1);
      check("br_pc_write", 32'(pc_write), 32'd0);
      step(OP_R, 1'b0, 0);
      exp_cnt++;
      check_count();
   endtask

   int  lw_st[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
   bit  lw_mr[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   int  sr_st[9]  = '{0, 1, 2, 5, 0, 1, 6, 7, 0};
   bit  sr_mr[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      drive(1'b1, OP_R, 1'b0);
      drive(1'b1, OP_R, 1'b1);
      check("rst_state", 32'(state), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd1);
      check("rst_alu_src_b", 32'(alu_src_b), 32'd1);
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_iord", 32'(iord), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check_count();

      // lw with stalls in FETCH and MEMRD
      for (int i = 0; i < 10; i++) begin
         step(OP_LW, lw_mr[i], lw_st[i]);
         check("lw_reg_write", 32'(reg_write), 32'(lw_st[i] == 4));
         check("lw_mem_to_reg", 32'(mem_to_reg), 32'(lw_st[i] == 4));
         check("lw_iord", 32'(iord), 32'(lw_st[i] == 3));
         check("lw_ir_write", 32'(ir_write), 32'(lw_st[i] == 0 && lw_mr[i]));
      end
      exp_cnt = 1;
      check_count();

      // sw then R-type
      for (int i = 0; i < 9; i++) begin
         step((i < 4) ? OP_SW : OP_R, sr_mr[i], sr_st[i]);
         check("sr_mem_write", 32'(mem_write), 32'(sr_st[i] == 5));
         if (sr_st[i] == 6) check("exec_alu_op", 32'(alu_op), 32'd4);
         if (sr_st[i] == 7) check("aluwb_reg_dst", 32'(reg_dst), 32'd1);
      end
      exp_cnt = 3;
      check_count();

      imm_instr(OP_ADDI, 1);
      imm_instr(OP_ANDI, 2);
      imm_instr(OP_ORI, 3);
      branch_instr(OP_BEQ, 1'b1, 1'b0);
      branch_instr(OP_BNE, 1'b0, 1'b1);

      // undefined opcode
      step(OP_BAD, 1'b1, 0);
      step(OP_BAD, 1'b1, 1);
      check("illegal_decode", 32'(illegal), 32'd0);
      step(OP_BAD, 1'b0, 0);
      check("illegal_pulse", 32'(illegal), 32'd1);
      step(OP_R, 1'b0, 0);
      check("illegal_clear", 32'(illegal), 32'd0);
      check_count();

      // jump opcode
      step(OP_J, 1'b1, 0);
      step(OP_J, 1'b1, 1);
`ifdef CTRL_JUMP_EN
      step(OP_J, 1'b0, 11);
      check("jump_pc_write", 32'(pc_write), 32'd1);
      check("jump_pc_source", 32'(pc_source), 32'd2);
      step(OP_R, 1'b0, 0);
      exp_cnt++;
      check_count();
`else
      step(OP_J, 1'b0, 0);
      check("j_illegal", 32'(illegal), 32'd1);
      check_count();
`endif

      // reset during a stalled MEMRD
      step(OP_LW, 1'b1, 0);
      step(OP_LW, 1'b1, 1);
      step(OP_LW, 1'b1, 2);
      step(OP_LW, 1'b0, 3);
      step(OP_LW, 1'b0, 3);
      drive(1'b1, OP_LW, 1'b1);
      drive(1'b0, OP_R, 1'b0);
      check("rst_abort_state", 32'(state), 32'd0);
      check("rst_abort_reg_write", 32'(reg_write), 32'd0);
      exp_cnt = 0;
      check_count();

      // four retires wrap the 2-bit counter
      for (int i = 0; i < 4; i++) branch_instr(OP_BEQ, 1'b1, 1'b0);
      check("wrap_small", 32'(s_instr_count), 32'd0);
      check("wrap_big", 32'(instr_count), 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
